// File: rtl/usb_tx_pkt.sv
// rtl/usb_tx_pkt.sv - USB packet-level transmitter: PID, payload and CRC16 bytes to the serializer (optional watchdog: USB_TX_PKT_WDOG_EN)
module usb_tx_pkt #(
  parameter logic [9:0] WDOG_CYCLES = 10'd1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txpkt_start,
  output logic       txpkt_done,
  input  logic [3:0] txpkt_pid,
  input  logic [9:0] txpkt_len,
  input  logic [7:0] txpkt_data,
  output logic       txpkt_data_ack,
  output logic       ll_start,
  output logic [7:0] ll_data,
  output logic       ll_last,
  input  logic       ll_ack,
  input  logic       ll_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_WAIT
  } state_t;

  state_t      state;
  logic [3:0]  pid_r;
  logic [9:0]  cnt;
  logic [15:0] crc;
  logic [15:0] crc_upd;
  logic        is_data;
  logic        wdog_fire;

  // Reflected USB CRC16 (poly 0xA001), one whole byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Data PIDs (DATA0/1/2, MDATA) all end in 2'b11.
  assign is_data = (pid_r[1:0] == 2'b11);
  assign crc_upd = crc16_byte(crc, txpkt_data);

  // Payload byte is released the same cycle the serializer latches it.
  assign txpkt_data_ack = (state == S_DATA) && ll_ack;

`ifdef USB_TX_PKT_WDOG_EN
  logic [9:0] wdog;

  // Idle-activity counter: any handshake from either side restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n || txpkt_start || ll_ack || ll_done || state == S_IDLE)
      wdog <= 10'd0;
    else
      wdog <= wdog + 10'd1;
  end

  // Reaching the limit this cycle (and no handshake now) abandons the packet.
  assign wdog_fire = (state != S_IDLE) && (wdog == WDOG_CYCLES - 10'd1) && !ll_ack && !ll_done;
`else
  logic [9:0] unused_wdog;
  assign unused_wdog = WDOG_CYCLES;
  assign wdog_fire   = 1'b0;
`endif

  // Packet sequencer: walks PID -> payload -> CRC -> wait for EOP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pid_r      <= 4'd0;
      cnt        <= 10'd0;
      crc        <= 16'hFFFF;
      ll_start   <= 1'b0;
      txpkt_done <= 1'b0;
    end else begin
      ll_start   <= 1'b0;
      txpkt_done <= 1'b0;
      if (wdog_fire) begin
        state      <= S_IDLE;
        txpkt_done <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (txpkt_start) begin
              pid_r    <= txpkt_pid;
              cnt      <= txpkt_len;
              crc      <= 16'hFFFF;
              ll_start <= 1'b1;
              state    <= S_PID;
            end
          end
          S_PID: begin
            if (ll_ack) begin
              if (!is_data)         state <= S_WAIT;
              else if (cnt == 10'd0) state <= S_CRC_LO;
              else                  state <= S_DATA;
            end
          end
          S_DATA: begin
            if (ll_ack) begin
              crc <= crc_upd;
              cnt <= cnt - 10'd1;
              if (cnt == 10'd1) state <= S_CRC_LO;
            end
          end
          S_CRC_LO: begin
            if (ll_ack) state <= S_CRC_HI;
          end
          S_CRC_HI: begin
            if (ll_ack) state <= S_WAIT;
          end
          S_WAIT: begin
            if (ll_done) begin
              state      <= S_IDLE;
              txpkt_done <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Byte presented to the serializer follows the current state; payload passes straight through.
  always_comb begin
    ll_data = 8'h00;
    ll_last = 1'b0;
    case (state)
      S_PID: begin
        ll_data = {~pid_r, pid_r};
        ll_last = !is_data;
      end
      S_DATA:   ll_data = txpkt_data;
      S_CRC_LO: ll_data = ~crc[7:0];
      S_CRC_HI: begin
        ll_data = ~crc[15:8];
        ll_last = 1'b1;
      end
      default: begin
        ll_data = 8'h00;
        ll_last = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// tb/tb_usb_tx_pkt.sv - directed bench for usb_tx_pkt against a byte-sequence model
module tb_usb_tx_pkt;

`ifdef USB_TX_PKT_WDOG_EN
  localparam logic [9:0] WD = 10'd16;
`else
  localparam logic [9:0] WD = 10'd1023;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       txpkt_start;
  logic       txpkt_done;
  logic [3:0] txpkt_pid;
  logic [9:0] txpkt_len;
  logic [7:0] txpkt_data;
  logic       txpkt_data_ack;
  logic       ll_start;
  logic [7:0] ll_data;
  logic       ll_last;
  logic       ll_ack;
  logic       ll_done;

  usb_tx_pkt #(.WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .txpkt_start(txpkt_start), .txpkt_done(txpkt_done),
    .txpkt_pid(txpkt_pid), .txpkt_len(txpkt_len),
    .txpkt_data(txpkt_data), .txpkt_data_ack(txpkt_data_ack),
    .ll_start(ll_start), .ll_data(ll_data), .ll_last(ll_last),
    .ll_ack(ll_ack), .ll_done(ll_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic       pl;
  } ent_t;

  ent_t       exp_q[$];
  ent_t       seq_g[$];
  logic [7:0] pay[1024];
  int         total = 0;
  int         bad = 0;
  int         nack = 0;
  logic       chk_en = 1'b0;
  logic       exp_llstart = 1'b0;
  logic       exp_done = 1'b0;
  logic [7:0] eb;
  logic       el, ep;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Transmitted PID byte: upper nibble is the ones' complement of the PID.
  function automatic logic [7:0] m_pid(input logic [3:0] p);
    return 8'((15 - int'(p)) * 16 + int'(p));
  endfunction

  // USB CRC16 computed in the non-reflected (poly 0x8005, MSB-side) form, then bit-reversed and inverted.
  function automatic logic [15:0] m_crc(input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ pay[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    for (int j = 0; j < 16; j++) r[j] = c[15 - j];
    return ~r;
  endfunction

  // Expected wire bytes of one packet.
  task automatic build_exp(input logic [3:0] pid, input int len);
    logic [15:0] c;
    logic        dat;
    dat = (pid % 4) == 3;
    seq_g.delete();
    seq_g.push_back('{b: m_pid(pid), last: !dat, pl: 1'b0});
    if (dat) begin
      for (int i = 0; i < len; i++) seq_g.push_back('{b: pay[i], last: 1'b0, pl: 1'b1});
      c = m_crc(len);
      seq_g.push_back('{b: c[7:0], last: 1'b0, pl: 1'b0});
      seq_g.push_back('{b: c[15:8], last: 1'b1, pl: 1'b0});
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    exp_done    = 1'b0;
    exp_llstart = 1'b0;
  endtask

  // Compare every cycle: front of the expected byte queue (or zeros when none is outstanding).
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        eb = exp_q[0].b; el = exp_q[0].last; ep = exp_q[0].pl;
      end else begin
        eb = 8'h00; el = 1'b0; ep = 1'b0;
      end
      chk("ll_data", 32'(ll_data), 32'(eb));
      chk("ll_last", 32'(ll_last), 32'(el));
      chk("data_ack", 32'(txpkt_data_ack), 32'(ll_ack && ep));
      chk("ll_start", 32'(ll_start), 32'(exp_llstart));
      chk("txpkt_done", 32'(txpkt_done), 32'(exp_done));
      if (txpkt_data_ack) nack++;
      if (ll_ack && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic start_pkt(input logic [3:0] pid, input int len);
    build_exp(pid, len);
    txpkt_pid   = pid;
    txpkt_len   = 10'(len);
    txpkt_start = 1'b1;
    tick;
    txpkt_start = 1'b0;
    exp_q       = seq_g;
    exp_llstart = 1'b1;
    nack        = 0;
    txpkt_data  = pay[0];
  endtask

  // Full packet; leaves the bench in the cycle where txpkt_done is expected.
  task automatic send(input logic [3:0] pid, input int len, input bit poke);
    int idx;
    int n;
    idx = 0;
    start_pkt(pid, len);
    n = seq_g.size();
    for (int k = 0; k < n; k++) begin
      ll_ack = 1'b1;
      tick;
      ll_ack = 1'b0;
      if (seq_g[k].pl) begin
        idx++;
        if (idx < 1024) txpkt_data = pay[idx];
      end
      if (poke && k == 2) begin
        txpkt_start = 1'b1;
        txpkt_pid   = 4'h2;
        txpkt_len   = 10'd0;
      end
      tick;
      txpkt_start = 1'b0;
      tick;
    end
    ll_done = 1'b1;
    tick;
    ll_done  = 1'b0;
    exp_done = 1'b1;
    chk("ack_count", 32'(nack), ((pid % 4) == 3) ? 32'(len) : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; txpkt_start = 1'b0; txpkt_pid = 4'h0; txpkt_len = 10'd0;
    txpkt_data = 8'h00; ll_ack = 1'b0; ll_done = 1'b0;
    tick;
    tick;
    chk_en = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;

    chk("pin_pid_ack", 32'(m_pid(4'h2)), 32'hD2);
    chk("pin_pid_data1", 32'(m_pid(4'hB)), 32'h4B);
    chk("pin_crc_zlp", 32'(m_crc(0)), 32'h0000);
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
    chk("pin_crc_check", 32'(m_crc(9)), 32'hB4C8);

    // ACK handshake, len ignored
    send(4'h2, 7, 1'b0);
    tick; tick;
    // zero-length DATA1
    send(4'hB, 0, 1'b0);
    tick;
    // "123456789"
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
    send(4'h3, 9, 1'b0);
    tick;
    // start during DATA is ignored
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    send(4'h7, 6, 1'b1);
    tick;

    // reset in the middle of the payload
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'hA0 + i);
    start_pkt(4'h3, 5);
    ll_ack = 1'b1; tick; ll_ack = 1'b0; tick; tick;
    ll_ack = 1'b1; tick; ll_ack = 1'b0; txpkt_data = pay[1]; tick;
    rst_n = 1'b0;
    tick;
    exp_q.delete();
    rst_n = 1'b1;
    repeat (20) tick;
    send(4'h3, 3, 1'b0);
    tick;

    // maximum payload, then a NAK started in the txpkt_done cycle
    for (int i = 0; i < 1023; i++) pay[i] = 8'($urandom);
    send(4'hF, 1023, 1'b0);
    send(4'hA, 0, 1'b0);
    tick;

    // dead serializer after the PID byte
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'h10 + i);
    start_pkt(4'h3, 4);
    ll_ack = 1'b1;
    tick;
    ll_ack = 1'b0;
`ifdef USB_TX_PKT_WDOG_EN
    repeat (16) tick;
    exp_q.delete();
    exp_done = 1'b1;
    tick;
    repeat (3) tick;
`else
    repeat (2000) tick;
    rst_n = 1'b0;
    tick;
    exp_q.delete();
    rst_n = 1'b1;
    tick;
`endif
    send(4'hB, 2, 1'b0);
    tick;
    tick;

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
